// File: rtl/div_unit.sv
// Iterative 32-bit divider for DIV/DIVU: one restoring shift-subtract step per cycle.
// result = {remainder, quotient}; ready is a one-cycle pulse decoded from the END state.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        annul,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    output logic [63:0] result,
    output logic        ready
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StByZero = 2'd1;
    localparam logic [1:0] StOn     = 2'd2;
    localparam logic [1:0] StEnd    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // {partial remainder (33 bits), dividend/quotient (32 bits)}
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;

    logic        op1_neg, op2_neg;
    logic [31:0] op1_mag, op2_mag;

    logic        fits;
    logic [31:0] partial;
    logic [64:0] step;

    logic [31:0] quo_raw, rem_raw;
    logic [31:0] quo_fix, rem_fix;

    // Operand conditioning: magnitudes and sign flags of the live inputs.
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    always_comb begin
        op1_neg = signed_div & opdata1[31];
        op2_neg = signed_div & opdata2[31];
        op1_mag = op1_neg ? (~opdata1 + 32'd1) : opdata1;
        op2_mag = op2_neg ? (~opdata2 + 32'd1) : opdata2;
    end

    // One restoring step: shift left, trial-subtract the divisor, keep the difference if it fits.
    // The shifted remainder is work_q[64:31]; it always stays below 2*divisor, so the
    // difference fits in 32 bits whenever the subtraction succeeds.
    always_comb begin
        fits    = work_q[64:31] >= {2'b00, divisor_q};
        partial = work_q[62:31] - divisor_q;
        if (fits) begin
            step = {1'b0, partial, work_q[30:0], 1'b1};
        end else begin
            step = {work_q[63:0], 1'b0};
        end
    end

    // Sign fix-up of the final step: quotient negated on differing signs,
    // remainder follows the dividend.
    always_comb begin
        quo_raw = step[31:0];
        rem_raw = step[63:32];
        quo_fix = neg_quo_q ? (~quo_raw + 32'd1) : quo_raw;
        rem_fix = neg_rem_q ? (~rem_raw + 32'd1) : rem_raw;
    end

    // Next-state and datapath control; annul overrides everything except reset.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (opdata2 == 32'd0) begin
                        state_d = StByZero;
                    end else begin
                        // Operands are only sampled here; later input changes are ignored.
                        state_d   = StOn;
                        cnt_d     = 5'd0;
                        work_d    = {33'd0, op1_mag};
                        divisor_d = op2_mag;
                        neg_quo_d = op1_neg ^ op2_neg;
                        neg_rem_d = op1_neg;
                    end
                end
            end
            StByZero: begin
                state_d  = StEnd;
                result_d = 64'd0;
            end
            StOn: begin
                work_d = step;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = StEnd;
                    result_d = {rem_fix, quo_fix};
                end
            end
            StEnd: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (annul) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    // ready is a pure decode of the registered state, so start never reaches it combinationally.
    assign ready  = (state_q == StEnd);
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues expected {result, ready cycle},
// a monitor pops and compares on every ready pulse.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        annul;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic [63:0] result;
    logic        ready;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_exp = 64'd0;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .annul      (annul),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .result     (result),
        .ready      (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic, truncating division, remainder follows the dividend.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint na, nb, q, r;
        logic [31:0] q32, r32;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            na = $signed(a);
            nb = $signed(b);
        end else begin
            na = {32'd0, a};
            nb = {32'd0, b};
        end
        q   = na / nb;
        r   = na % nb;
        q32 = q[31:0];
        r32 = r[31:0];
        return {r32, q32};
    endfunction

    task automatic push_exp(input logic [63:0] e, input int c);
        exp_t it;
        it.res = e;
        it.cyc = c;
        exp_q.push_back(it);
    endtask

    // Monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            exp_t it;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready: got ready=1 at cycle %0d, expected none", cyc);
            end else begin
                it = exp_q.pop_front();
                checks++;
                if (result !== it.res) begin
                    errors++;
                    $display("FAIL result: got %h expected %h", result, it.res);
                end
                checks++;
                if (cyc != it.cyc) begin
                    errors++;
                    $display("FAIL ready_cycle: got %0d expected %0d", cyc, it.cyc);
                end
                last_exp = it.res;
            end
        end
    end

    // Waits for ready at negedges; optionally scrambles operands meanwhile.
    task automatic wait_ready(input bit scramble, output int rc);
        rc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                rc = cyc;
                break;
            end
            if (scramble) begin
                opdata1    = $urandom;
                opdata2    = $urandom;
                signed_div = ($urandom_range(0, 1) == 1);
            end
        end
        if (rc < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no ready within 40 cycles, expected a pulse");
            exp_q.delete();
            start = 1'b0;
        end
    endtask

    task automatic check_out(input string name, input logic [63:0] exp_res);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready: got %b expected 0", name, ready);
        end
        checks++;
        if (result !== exp_res) begin
            errors++;
            $display("FAIL %s_result: got %h expected %h", name, result, exp_res);
        end
    endtask

    // Full transaction from IDLE; caller is aligned #1 after a posedge.
    task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e, input bit hold);
        int rc;
        checks++;
        if (result !== last_exp) begin
            errors++;
            $display("FAIL result_hold: got %h expected %h", result, last_exp);
        end
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        @(posedge clk);
        #1;
        push_exp(e, cyc + ((b == 32'd0) ? 1 : 32));
        if (!hold) start = 1'b0;
        wait_ready(1'b1, rc);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ra, rb;
    bit          rs;
    int          sel;
    int          rc1, rc2;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        opdata1    = 32'd0;
        opdata2    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_out("idle", 64'd0);

        // Directed cases
        do_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 1'b1);
        do_div(1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
        do_div(1'b1, 32'h7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 1'b0);
        do_div(1'b0, 32'h1234, 32'h0, 64'd0, 1'b1);

        // Annul at cycle 10 with start still high: annul wins, then a fresh divide
        signed_div = 1'b0;
        opdata1    = 32'hDEAD_BEEF;
        opdata2    = 32'h3;
        start      = 1'b1;
        @(posedge clk);
        #1;
        repeat (8) @(posedge clk);
        #1;
        annul   = 1'b1;
        opdata1 = 32'hFFFF_FFFF;
        opdata2 = 32'h10;
        @(posedge clk);
        #1;
        annul = 1'b0;
        check_out("annul", last_exp);
        do_div(1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 1'b1);

        // Reset at cycle 20 with start and annul also high: reset wins
        signed_div = 1'b1;
        opdata1    = 32'h1234_5678;
        opdata2    = 32'h345;
        start      = 1'b1;
        @(posedge clk);
        #1;
        repeat (18) @(posedge clk);
        #1;
        rst     = 1'b1;
        annul   = 1'b1;
        opdata1 = 32'h8000_0000;
        opdata2 = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        annul = 1'b0;
        check_out("midrst", 64'd0);
        last_exp = 64'd0;
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b1);

        // Back-to-back: start held through END, second request picked up after END
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd33;
        start      = 1'b1;
        @(posedge clk);
        #1;
        push_exp(ref_div(1'b0, 32'd1000, 32'd33), cyc + 32);
        wait_ready(1'b1, rc1);
        if (rc1 >= 0) begin
            signed_div = 1'b1;
            opdata1    = 32'hF000_0001;
            opdata2    = 32'h0000_0123;
            push_exp(ref_div(1'b1, 32'hF000_0001, 32'h0000_0123), rc1 + 34);
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            wait_ready(1'b1, rc2);
        end
        start = 1'b0;
        @(posedge clk);
        #1;

        // Randomized divides against the reference model
        for (int n = 0; n < 24; n++) begin
            rs  = ($urandom_range(0, 1) == 1);
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: rb = 32'hFFFF_FFFF;
                3: begin
                    ra = 32'h8000_0000;
                    rb = $urandom;
                end
                4: rb = ra;
                default: rb = $urandom;
            endcase
            do_div(rs, ra, rb, ref_div(rs, ra, rb), ($urandom_range(0, 1) == 1));
        end

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d outstanding expectations, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
